classic_mul_seq: RTL

CLASSIC_MUL_SEQ -- requirements
Module: classic_mul_seq

---
 rtl/classic_mul_pkg.sv | 20 ++
 rtl/classic_half_mul.sv | 15 +
 rtl/classic_mul_seq.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/classic_mul_pkg.sv
// rtl/classic_mul_pkg.sv - shared FSM encoding, PP-cycle count and half-width helper for classic_mul_seq
package classic_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PP   = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mul_state_t;

    // One partial product per cycle: aL*bL, aH*bL, aL*bH, aH*bH.
    localparam int PP_CYCLES = 4;
    localparam int K_W       = 2;
    localparam logic [K_W-1:0] PP_LAST = K_W'(PP_CYCLES - 1);

    function automatic int half_width(input int width);
        return width / 2;
    endfunction

endpackage

// File: rtl/classic_half_mul.sv
// rtl/classic_half_mul.sv - combinational HALF x HALF unsigned multiplier
// Ports:
//   x, y : HALF-bit unsigned operands
//   p    : 2*HALF-bit unsigned product
module classic_half_mul #(
    parameter int HALF = 16
) (
    input  logic [HALF-1:0]   x,
    input  logic [HALF-1:0]   y,
    output logic [2*HALF-1:0] p
);

    assign p = {{HALF{1'b0}}, x} * {{HALF{1'b0}}, y};

endmodule

// File: rtl/classic_mul_seq.sv
// rtl/classic_mul_seq.sv - sequential multiplier summing four half-width partial products
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_ready  : operand handshake (accepted only in IDLE)
//   a, b, is_signed     : operands and two's-complement mode select
//   out_valid, out_ready: product handshake (held in DONE until out_ready)
//   out                 : 2*WIDTH product, taken straight from the accumulator
module classic_mul_seq
    import classic_mul_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out
);

    localparam int HALF = half_width(WIDTH);
    localparam int W2   = 2 * WIDTH;

    mul_state_t       state_q, state_d;
    logic [K_W-1:0]   k_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             sign_q;
    logic [W2-1:0]    acc_q;

    logic             signed_mode;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             accept;

    logic [HALF-1:0]  mul_x, mul_y;
    logic [WIDTH-1:0] pp;
    logic [W2-1:0]    pp_ext, pp_shifted;

    assign signed_mode = SIGNED_EN && is_signed;
    assign a_neg       = signed_mode && a[WIDTH-1];
    assign b_neg       = signed_mode && b[WIDTH-1];
    // Negating -2^(WIDTH-1) wraps back to the same bit pattern, which read
    // as unsigned is exactly the required magnitude 2^(WIDTH-1).
    assign a_mag       = a_neg ? (-a) : a;
    assign b_mag       = b_neg ? (-b) : b;
    assign accept      = (state_q == IDLE) && in_valid;

    // k[0] picks the high half of a, k[1] the high half of b, so the single
    // multiplier walks aL*bL, aH*bL, aL*bH, aH*bH.
    always_comb begin
        mul_x = k_q[0] ? a_q[WIDTH-1:HALF] : a_q[HALF-1:0];
        mul_y = k_q[1] ? b_q[WIDTH-1:HALF] : b_q[HALF-1:0];
    end

    classic_half_mul #(
        .HALF (HALF)
    ) u_half_mul (
        .x (mul_x),
        .y (mul_y),
        .p (pp)
    );

    assign pp_ext = {{WIDTH{1'b0}}, pp};

    always_comb begin
        pp_shifted = pp_ext;
        case (k_q)
            2'd1, 2'd2: pp_shifted = pp_ext << HALF;
            2'd3:       pp_shifted = pp_ext << WIDTH;
            default:    pp_shifted = pp_ext;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = PP;
            end
            PP: begin
                if (k_q == PP_LAST) state_d = FIX;
            end
            FIX: begin
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sign_q <= 1'b0;
            acc_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q    <= a_mag;
                        b_q    <= b_mag;
                        sign_q <= a_neg ^ b_neg;
                        acc_q  <= '0;
                        k_q    <= '0;
                    end
                end
                PP: begin
                    acc_q <= acc_q + pp_shifted;
                    k_q   <= k_q + 1'b1;
                end
                FIX: begin
                    if (sign_q) acc_q <= -acc_q;
                end
                default: begin
                end
            endcase
        end
    end

    // Outside DONE this is the running (or last) accumulator value.
    assign out = acc_q;

endmodule
